// File: rtl/muon_decay_trigger.sv
// muon_decay_trigger
//   Double-pulse discriminator feeding the capture RAM. Looks for a muon pulse followed
//   by a decay-electron pulse within a programmable window. On a valid pair it emits a
//   stretched trigger, reports the decay time in clka cycles and counts the event.
//   After each trigger or timeout it waits out a holdoff, then re-arms.
//
// Ports
//   clka            sample clock, all logic on posedge
//   int_rst         asynchronous, active-high reset
//   i_adc_in        14-bit two's complement ADC sample
//   i_polarity      1 = negative-going pulses (sample inverted before compare)
//   i_threshold     signed discriminator level, applied after inversion
//   i_window        max cycles from first to second crossing, inclusive
//   i_holdoff       dead cycles after a trigger/timeout (0 behaves as 1)
//   i_arm           level enable; low forces idle
//   o_trig          trigger, TRIG_LEN cycles high
//   o_decay_valid   1-cycle strobe qualifying o_decay_time
//   o_decay_time    cycles between first and second crossing, held until next accept
//   o_event_count   accepted pairs since reset, wrapping
//   o_busy          high outside the idle and wait-for-first states
//   o_trig_ts       (TRIG_TIMESTAMP_EN only) free-running cycle count latched on accept
//
// Build option: define TRIG_TIMESTAMP_EN to add o_trig_ts.
module muon_decay_trigger #(
  parameter int unsigned TRIG_LEN = 4,
  parameter int unsigned HYST     = 16,
  parameter int unsigned TW       = 16
) (
  input  logic          clka,
  input  logic          int_rst,
  input  logic [13:0]   i_adc_in,
  input  logic          i_polarity,
  input  logic [13:0]   i_threshold,
  input  logic [TW-1:0] i_window,
  input  logic [TW-1:0] i_holdoff,
  input  logic          i_arm,
  output logic          o_trig,
  output logic          o_decay_valid,
  output logic [TW-1:0] o_decay_time,
  output logic [31:0]   o_event_count,
  output logic          o_busy
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [47:0]   o_trig_ts
`endif
);

  localparam int unsigned TCW = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;

  typedef enum logic [2:0] {
    StIdle, StRearm, StWaitFirst, StInFirst, StWaitSecond, StHoldoff
  } state_e;

  state_e               r_state, w_state_d;
  logic signed [14:0]   r_s, w_s_next, w_adc_ext, w_thr, w_thr_lo;
  logic                 w_above, w_below;
  logic [TW-1:0]        r_dcnt, w_dcnt_d, w_dcnt_inc;
  logic [TW-1:0]        r_hcnt, w_hcnt_d;
  logic                 w_hold_done, w_acc;
  logic                 r_acc;
  logic [TW-1:0]        r_acc_time;
  logic                 r_trig;
  logic [TCW-1:0]       r_tcnt;
  logic                 r_dv;
  logic [TW-1:0]        r_dtime;
  logic [31:0]          r_evcnt;

  // Inversion in 15 bits; only -8192 would overflow 14 bits, so clamp it to +8191.
  assign w_adc_ext = $signed({i_adc_in[13], i_adc_in});
  always_comb begin
    w_s_next = w_adc_ext;
    if (i_polarity) begin
      w_s_next = (i_adc_in == 14'h2000) ? 15'sd8191 : -w_adc_ext;
    end
  end

  // 15-bit signed compares: threshold - HYST cannot wrap.
  assign w_thr    = $signed({i_threshold[13], i_threshold});
  assign w_thr_lo = w_thr - $signed(15'(HYST));
  assign w_above  = (r_s >= w_thr);
  assign w_below  = (r_s < w_thr_lo);

  // Decay counter saturates rather than wrapping.
  assign w_dcnt_inc  = (&r_dcnt) ? r_dcnt : r_dcnt + TW'(1);
  assign w_hold_done = (i_holdoff == '0) || (r_hcnt >= i_holdoff - TW'(1));

  always_comb begin
    w_state_d = r_state;
    w_dcnt_d  = r_dcnt;
    w_hcnt_d  = r_hcnt;
    w_acc     = 1'b0;
    if (!i_arm) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: w_state_d = StRearm;
        StRearm: begin
          if (w_below) w_state_d = StWaitFirst;
        end
        StWaitFirst: begin
          if (w_above) begin
            w_dcnt_d  = '0;
            w_state_d = StInFirst;
          end
        end
        StInFirst: begin
          w_dcnt_d = w_dcnt_inc;
          if (w_dcnt_inc > i_window) begin
            w_hcnt_d  = '0;
            w_state_d = StHoldoff;
          end else if (w_below) begin
            w_state_d = StWaitSecond;
          end
        end
        StWaitSecond: begin
          w_dcnt_d = w_dcnt_inc;
          if (w_dcnt_inc > i_window) begin
            w_hcnt_d  = '0;
            w_state_d = StHoldoff;
          end else if (w_above) begin
            w_acc     = 1'b1;
            w_hcnt_d  = '0;
            w_state_d = StHoldoff;
          end
        end
        StHoldoff: begin
          if (w_hold_done) w_state_d = StRearm;
          else             w_hcnt_d  = r_hcnt + TW'(1);
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clka or posedge int_rst) begin
    if (int_rst) begin
      r_state    <= StIdle;
      r_s        <= '0;
      r_dcnt     <= '0;
      r_hcnt     <= '0;
      r_acc      <= 1'b0;
      r_acc_time <= '0;
    end else begin
      r_state    <= w_state_d;
      r_s        <= w_s_next;
      r_dcnt     <= w_dcnt_d;
      r_hcnt     <= w_hcnt_d;
      r_acc      <= w_acc;
      if (w_acc) r_acc_time <= w_dcnt_inc;
    end
  end

  // Accept is reported one cycle after the decision; the stretch runs to completion
  // even if arm drops.
  always_ff @(posedge clka or posedge int_rst) begin
    if (int_rst) begin
      r_trig  <= 1'b0;
      r_tcnt  <= '0;
      r_dv    <= 1'b0;
      r_dtime <= '0;
      r_evcnt <= '0;
    end else begin
      r_dv <= r_acc;
      if (r_acc) begin
        r_trig  <= 1'b1;
        r_tcnt  <= TCW'(TRIG_LEN - 1);
        r_dtime <= r_acc_time;
        r_evcnt <= r_evcnt + 32'd1;
      end else if (r_tcnt != '0) begin
        r_tcnt <= r_tcnt - TCW'(1);
      end else begin
        r_trig <= 1'b0;
      end
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [47:0] r_ts, r_trig_ts;
  always_ff @(posedge clka or posedge int_rst) begin
    if (int_rst) begin
      r_ts      <= '0;
      r_trig_ts <= '0;
    end else begin
      r_ts <= r_ts + 48'd1;
      if (r_acc) r_trig_ts <= r_ts;
    end
  end
  assign o_trig_ts = r_trig_ts;
`endif

  assign o_trig        = r_trig;
  assign o_decay_valid = r_dv;
  assign o_decay_time  = r_dtime;
  assign o_event_count = r_evcnt;
  assign o_busy        = (r_state != StIdle) && (r_state != StWaitFirst);

endmodule
